// File: rtl/renkon_pkg.sv
// Shared constants, pixel type and pooling FSM state encoding for the renkon datapath.
package renkon_pkg;

    localparam int DWIDTH    = 16;
    localparam int MAXIMG    = 32;
    localparam int SIZE_W    = $clog2(MAXIMG + 1);
    localparam int BUF_DEPTH = MAXIMG / 2;
    localparam int BUF_AW    = $clog2(BUF_DEPTH);

    typedef logic signed [DWIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } pool_state_t;

endpackage

// File: rtl/renkon_pool_linebuf.sv
// Half-row line buffer for max pooling: synchronous write, combinational read.
// Kept as a separate module so it can be replaced by a vendor RAM macro.
module renkon_pool_linebuf
    import renkon_pkg::*;
#(
    parameter  int DEPTH = BUF_DEPTH,
    parameter  int WIDTH = DWIDTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/renkon_pool_max.sv
// renkon_pool_max: streaming 2x2 stride-2 max pooling using a half-row line buffer.
// Define RENKON_POOL_RELU_EN to clamp negative pooled values to zero (fused ReLU).
module renkon_pool_max
    import renkon_pkg::*;
(
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     init,
    input  logic [SIZE_W-1:0]        img_size,
    input  logic                     in_valid,
    input  logic signed [DWIDTH-1:0] pixel_in,
    output logic                     out_valid,
    output logic signed [DWIDTH-1:0] pixel_out,
    output logic                     busy,
    output logic                     done
);

    pool_state_t state, state_nxt;

    logic [SIZE_W-1:0]        size;
    logic [SIZE_W-1:0]        col;
    logic [SIZE_W-1:0]        row;
    logic [SIZE_W-1:0]        last_idx;
    logic                     accept_p0;
    logic                     col_last_p0;
    logic                     row_last_p0;
    logic                     hwrite_p0;
    logic                     emit_p0;
    logic [BUF_AW-1:0]        buf_addr_p0;
    logic signed [DWIDTH-1:0] hold_p0;
    logic signed [DWIDTH-1:0] hmax_p0;
    logic signed [DWIDTH-1:0] buf_rd_p0;
    logic signed [DWIDTH-1:0] vmax_p0;

    function automatic logic signed [DWIDTH-1:0] smax(
        input logic signed [DWIDTH-1:0] a,
        input logic signed [DWIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [DWIDTH-1:0] relu(input logic signed [DWIDTH-1:0] a);
`ifdef RENKON_POOL_RELU_EN
        return a[DWIDTH-1] ? '0 : a;
`else
        return a;
`endif
    endfunction

    // An init in the same cycle as a pixel wins: the pixel belongs to the aborted map.
    assign last_idx    = size - SIZE_W'(1);
    assign accept_p0   = in_valid && (state == S_RUN) && !init;
    assign col_last_p0 = (col == last_idx);
    assign row_last_p0 = (row == last_idx);
    assign hwrite_p0   = accept_p0 && !row[0] && col[0];
    assign emit_p0     = accept_p0 && row[0] && col[0];
    assign buf_addr_p0 = col[BUF_AW:1];
    assign hmax_p0     = smax(hold_p0, pixel_in);
    assign vmax_p0     = smax(buf_rd_p0, hmax_p0);

    renkon_pool_linebuf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DWIDTH)
    ) u_linebuf (
        .clk   (clk),
        .we    (hwrite_p0),
        .addr  (buf_addr_p0),
        .wdata (hmax_p0),
        .rdata (buf_rd_p0)
    );

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (init) state_nxt = S_RUN;
            S_RUN:  if (accept_p0 && col_last_p0 && row_last_p0) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            size <= '0;
            col  <= '0;
            row  <= '0;
        end else if (init && (state != S_DONE)) begin
            size <= img_size;
            col  <= '0;
            row  <= '0;
        end else if (accept_p0) begin
            if (col_last_p0) begin
                col <= '0;
                row <= row_last_p0 ? '0 : row + SIZE_W'(1);
            end else begin
                col <= col + SIZE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept_p0 && !col[0]) begin
            hold_p0 <= pixel_in;
        end
    end

    // p0 -> p1: registered pooled output
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            out_valid <= 1'b0;
            pixel_out <= '0;
        end else begin
            out_valid <= emit_p0;
            if (emit_p0) begin
                pixel_out <= relu(vmax_p0);
            end
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: doc/renkon_pool_max.md
# renkon_pool_max

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of `renkon_conv` in the renkon datapath. It consumes one feature map's conv outputs in raster order and emits the pooled map in raster order. Horizontal pairs are reduced on the fly, and half a row of partial maxima is buffered, so pooling needs no frame memory.

## Interface
- `DWIDTH`, 16: signed pixel width.
- `MAXIMG`, 32: maximum input map side; the line buffer depth is `MAXIMG/2`.
- `clk`, in, 1: single clock, rising edge.
- `xrst`, in, 1: reset, asynchronous, active-low.
- `init`, in, 1: start pulse; samples `img_size` and clears counters.
- `img_size`, in, `$clog2(MAXIMG+1)`: input map side; legal range 2..`MAXIMG`.
- `in_valid`, in, 1: `pixel_in` is valid this cycle.
- `pixel_in`, in, `DWIDTH`, signed: conv output pixel.
- `out_valid`, out, 1: `pixel_out` is valid this cycle.
- `pixel_out`, out, `DWIDTH`, signed: pooled pixel.
- `busy`, out, 1: high from `init` until the map completes.
- `done`, out, 1: one-cycle pulse after the last pooled pixel.

## Operation
- **FSM states:** `S_IDLE`, `S_RUN`, `S_DONE`.
  - `S_IDLE` → `S_RUN` on `init`.
  - `S_RUN` → `S_DONE` when the pixel at row=`size`-1, col=`size`-1 is accepted.
  - `S_DONE` → `S_IDLE` unconditionally.
- **Counters:** `col` and `row` advance only on `in_valid` in `S_RUN`. `col` wraps at `size`-1 and increments `row`.
- **Horizontal reduction:**
  - Even `col`: latch `pixel_in` into the hold register.
  - Odd `col`: `hmax = max(hold, pixel_in)`, signed compare.
- **Row handling:**
  - Even `row`, odd `col`: write `hmax` to `buf[col>>1]`.
  - Odd `row`, odd `col`: `pixel_out = max(buf[col>>1], hmax)` and assert `out_valid`.
- **Odd `img_size`:** the trailing column and row are consumed but ignored. The output size is `floor(size/2)`.
- **Arithmetic:** comparison only, so there is no width growth. `pixel_out` equals an input value exactly.
- **`in_valid` outside `S_RUN`:** ignored.
- **`init` while in `S_RUN`:** aborts the current map. Counters clear, `size` is reloaded, the buffer contents are treated as stale (always overwritten on an even row before being read), and the state stays `S_RUN`. No `done` pulse is issued for the aborted map.
- **Reset mid-operation:** all state returns to reset values immediately. The buffer RAM is not cleared.

## Timing
- **Reset values:** `out_valid`=0, `pixel_out`=0, `busy`=0, `done`=0, state=`S_IDLE`, counters=0.
- **Output latency:** `out_valid` asserts exactly one cycle after the accepting edge of an odd-row/odd-col input (registered output). `pixel_out` holds its value until the next output.
- **`busy`:** rises the cycle after `init` and falls in the same cycle that `done` pulses.
- **`done`:** one cycle, asserted in `S_DONE`, i.e. one cycle after the final input is accepted. It coincides with the last `out_valid` when `size` is even.
- **Input rate:** `in_valid` may be continuous, one pixel per cycle, with no backpressure. Gaps are allowed.
- **Buffer access:** read and write of `buf` for a given column never occur in the same cycle (different row parity), so there is no read/write hazard.

## Configuration
- `RENKON_POOL_RELU_EN` defined: fused ReLU; `pixel_out` = `max(pool, 0)`, with negatives emitted as 0. This is valid because max and ReLU commute.
- Macro undefined: the signed pooled value is passed unchanged.

## Structure
- **`renkon_pkg`:** `DWIDTH`, `MAXIMG`, the `pool_state_t` enum (`S_IDLE`, `S_RUN`, `S_DONE`) and the signed pixel typedef.
- **Sub-module `renkon_pool_linebuf`:** single-port `MAXIMG/2` × `DWIDTH` RAM with synchronous write and combinational read. It is isolated so it can be swapped for a BRAM macro.

## Test plan
- **Monotonic 4×4 map:** `size`=4, inputs 0..15 → outputs 5, 7, 13, 15; `done` one cycle after input 15.
- **Signed values, ReLU off:** all-negative 2×2 {-3, -1, -7, -2} → output -1. With `RENKON_POOL_RELU_EN` defined → output 0.
- **Odd size:** `size`=5, inputs 0..24 → outputs 6, 8, 16, 18; row 4 and col 4 are ignored; `done` after input 24.
- **Gapped input:** `size`=4 with `in_valid` toggling every other cycle → same outputs as the monotonic test, each one cycle after its completing input.
- **Re-`init` mid-map:** `init` after 6 pixels, then a fresh `size`=2 map {9, 1, 2, 3} → single output 9, one `done`, no stale output.
- **Reset mid-map:** drop `xrst` for 1 cycle at pixel 10 → all outputs 0, `busy`=0, state `S_IDLE`; a following `init` runs a clean map.
